// File: rtl/qerv_bufreg_w.sv
// Buffer register for the W-bit-serial core: serial rs1+imm accumulator,
// data-bus address source, LSU lane/misalign decode and operand shifter.
module qerv_bufreg_w #(
    parameter int unsigned MDU            = 0,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cnt0,
    input  logic                      i_en,
    input  logic                      i_init,
    input  logic                      i_mdu_op,
    input  logic                      i_rs1_en,
    input  logic                      i_imm_en,
    input  logic                      i_clr_lsb,
    input  logic                      i_shift_op,
    input  logic                      i_right_shift_op,
    input  logic                      i_sh_signed,
    input  logic [1:0]                i_lsu_size,
    input  logic [BITS_PER_CYCLE-1:0] i_rs1,
    input  logic [BITS_PER_CYCLE-1:0] i_imm,
    input  logic [LB:0]               i_shamt_lsb,
    output logic [BITS_PER_CYCLE-1:0] o_q,
    output logic [1:0]                o_lsb,
    output logic                      o_misalign,
    output logic [3:0]                o_byte_en,
    output logic [31:0]               o_dbus_adr,
    output logic [31:0]               o_ext_rs1
);

    localparam int unsigned W   = BITS_PER_CYCLE;
    localparam logic [LB:0] W_L = W[LB:0];

    logic [31:0]    data_q, data_d;
    logic           c_q, c_d;
    logic [1:0]     lsb_q, lsb_d;
    logic [2*W-1:0] spill_q, spill_d;
    logic           misalign_q, misalign_d;

    logic [W-1:0]   rs1_g, imm_m, imm_g, q, fill;
    logic [W:0]     sum;
    logic [LB:0]    s;
    logic [2*W-1:0] sh;
    logic           lsb_upd;

    always_comb begin
        imm_m = i_imm;
        if (i_cnt0 && i_clr_lsb) imm_m[0] = 1'b0;
        rs1_g = i_rs1_en ? i_rs1 : '0;
        imm_g = i_imm_en ? imm_m : '0;
        sum   = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, c_q};
        q     = sum[W-1:0];
        c_d   = sum[W] & i_en;
    end

    always_comb begin
        fill   = i_init ? q : (i_sh_signed ? {W{data_q[31]}} : '0);
        data_d = data_q;
        if (i_en) data_d = {fill, data_q[31:W]};
    end

    // Right shifts use the complementary left amount; the coarse counter outside
    // supplies the extra chunk of delay.
    always_comb begin
        s = '0;
        if (i_shift_op) begin
            if (i_right_shift_op)
                s = (i_shamt_lsb == '0) ? '0 : W_L - i_shamt_lsb;
            else
                s = i_shamt_lsb;
        end
        sh      = {{W{1'b0}}, data_q[W-1:0]} << s;
        spill_d = spill_q;
        if (i_en)
            spill_d = sh;
        else if (i_cnt0)
            spill_d = '0;
        o_q = i_en ? (sh[W-1:0] | spill_q[2*W-1:W]) : '0;
    end

    if (W == 1) begin : g_bit
        // With one bit per cycle, address bit 1 arrives on the enabled cycle after cnt0.
        logic cnt1_q, cnt1_d;

        always_comb begin
            lsb_d   = lsb_q;
            lsb_upd = 1'b0;
            cnt1_d  = cnt1_q;
            if (i_en) begin
                cnt1_d = i_cnt0 & i_init;
                if (i_cnt0 && i_init) lsb_d[0] = q[0];
                if (cnt1_q) begin
                    lsb_d[1] = q[0];
                    lsb_upd  = 1'b1;
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) cnt1_q <= 1'b0;
            else       cnt1_q <= cnt1_d;
        end
    end else begin : g_chunk
        always_comb begin
            lsb_upd = i_en & i_cnt0 & i_init;
            lsb_d   = lsb_upd ? q[1:0] : lsb_q;
        end
    end

    always_comb begin
        misalign_d = misalign_q;
        if (lsb_upd) begin
            case (i_lsu_size)
                2'b01:   misalign_d = lsb_d[0];
                2'b10:   misalign_d = |lsb_d;
                default: misalign_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q     <= '0;
            c_q        <= 1'b0;
            lsb_q      <= '0;
            spill_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            c_q        <= c_d;
            lsb_q      <= lsb_d;
            spill_q    <= spill_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        case (i_lsu_size)
            2'b00:   o_byte_en = 4'b0001 << lsb_q;
            2'b01:   o_byte_en = 4'b0011 << {lsb_q[1], 1'b0};
            default: o_byte_en = 4'b1111;
        endcase
        o_lsb      = ((MDU != 0) && i_mdu_op) ? 2'b00 : lsb_q;
        o_misalign = misalign_q;
        o_dbus_adr = {data_q[31:2], 2'b00};
        o_ext_rs1  = {data_q[31:2], lsb_q};
    end

endmodule

// File: tb/tb_qerv_bufreg_w.sv
// Directed bench: W=2, W=4 and W=8 (MDU) instances driven one pass at a time.
module tb_qerv_bufreg_w;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cnt0 = 0, init = 0, mdu_op = 0, rs1_en = 1, imm_en = 1, clr_lsb = 0;
    logic       shift_op = 0, right = 0, sh_signed = 0;
    logic [1:0] size = 2'b00;
    logic [7:0] rs1_c = '0, imm_c = '0;
    logic [3:0] shamt = '0;
    logic       en2 = 0, en4 = 0, en8 = 0;

    logic [1:0] q2;  logic [3:0] q4;  logic [7:0] q8;
    logic [1:0] lsb2, lsb4, lsb8;
    logic       mis2, mis4, mis8;
    logic [3:0] be2, be4, be8;
    logic [31:0] adr2, adr4, adr8, ext2, ext4, ext8;

    int checks = 0;
    int errors = 0;
    logic [31:0] qs;

    qerv_bufreg_w #(.MDU(0), .BITS_PER_CYCLE(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_cnt0(cnt0), .i_en(en2), .i_init(init),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_shift_op(shift_op), .i_right_shift_op(right), .i_sh_signed(sh_signed),
        .i_lsu_size(size), .i_rs1(rs1_c[1:0]), .i_imm(imm_c[1:0]), .i_shamt_lsb(shamt[1:0]),
        .o_q(q2), .o_lsb(lsb2), .o_misalign(mis2), .o_byte_en(be2),
        .o_dbus_adr(adr2), .o_ext_rs1(ext2));

    qerv_bufreg_w #(.MDU(0), .BITS_PER_CYCLE(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_cnt0(cnt0), .i_en(en4), .i_init(init),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_shift_op(shift_op), .i_right_shift_op(right), .i_sh_signed(sh_signed),
        .i_lsu_size(size), .i_rs1(rs1_c[3:0]), .i_imm(imm_c[3:0]), .i_shamt_lsb(shamt[2:0]),
        .o_q(q4), .o_lsb(lsb4), .o_misalign(mis4), .o_byte_en(be4),
        .o_dbus_adr(adr4), .o_ext_rs1(ext4));

    qerv_bufreg_w #(.MDU(1), .BITS_PER_CYCLE(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_cnt0(cnt0), .i_en(en8), .i_init(init),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_shift_op(shift_op), .i_right_shift_op(right), .i_sh_signed(sh_signed),
        .i_lsu_size(size), .i_rs1(rs1_c), .i_imm(imm_c), .i_shamt_lsb(shamt),
        .o_q(q8), .o_lsb(lsb8), .o_misalign(mis8), .o_byte_en(be8),
        .o_dbus_adr(adr8), .o_ext_rs1(ext8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full pass of 32/w enabled cycles on the instance of width w, then idle.
    task automatic pass(input int w, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic ini, output logic [31:0] qcol);
        qcol = '0;
        for (int k = 0; k < 32 / w; k++) begin
            @(negedge clk);
            cnt0  = (k == 0);
            init  = ini;
            rs1_c = 8'(rs1 >> (k * w));
            imm_c = 8'(imm >> (k * w));
            en2   = (w == 2);
            en4   = (w == 4);
            en8   = (w == 8);
            #1;
            case (w)
                2:       qcol = qcol | (32'(q2) << (k * w));
                4:       qcol = qcol | (32'(q4) << (k * w));
                default: qcol = qcol | (32'(q8) << (k * w));
            endcase
        end
        @(negedge clk);
        en2 = 0; en4 = 0; en8 = 0; cnt0 = 0; init = 0;
    endtask

    initial begin
        #12;
        check("rst_adr4", adr4, 32'h0);
        check("rst_lsb4", 32'(lsb4), 32'h0);
        check("rst_mis4", 32'(mis4), 32'h0);
        check("rst_be4", 32'(be4), 32'h1);
        check("rst_q4", 32'(q4), 32'h0);
        check("rst_adr8", adr8, 32'h0);
        @(negedge clk);
        rst = 0;

        size = 2'b10;
        pass(4, 32'h0000_1000, 32'h0000_0FFC, 1'b1, qs);
        check("w4_sum_adr", adr4, 32'h0000_1FFC);
        check("w4_sum_lsb", 32'(lsb4), 32'h0);
        check("w4_sum_mis", 32'(mis4), 32'h0);
        check("w4_sum_be", 32'(be4), 32'hF);

        pass(4, 32'h0000_000F, 32'h0000_0001, 1'b1, qs);
        check("w4_carry", ext4, 32'h0000_0010);
        pass(4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, qs);
        check("w4_wrap", ext4, 32'h0);
        pass(4, 32'h0000_0004, 32'h0000_0003, 1'b1, qs);
        check("w4_stale_carry", ext4, 32'h0000_0007);

        size = 2'b10;
        pass(2, 32'h0000_1001, 32'h0, 1'b1, qs);
        check("w2_word_mis", 32'(mis2), 32'h1);
        check("w2_word_lsb", 32'(lsb2), 32'h1);
        check("w2_word_adr", adr2, 32'h0000_1000);
        size = 2'b00;
        pass(2, 32'h0000_1001, 32'h0, 1'b1, qs);
        check("w2_byte_mis", 32'(mis2), 32'h0);
        check("w2_byte_be", 32'(be2), 32'h2);
        size = 2'b01;
        pass(2, 32'h0000_1002, 32'h0, 1'b1, qs);
        check("w2_half_mis", 32'(mis2), 32'h0);
        check("w2_half_be", 32'(be2), 32'hC);
        pass(2, 32'h0000_1003, 32'h0, 1'b1, qs);
        check("w2_half_odd_mis", 32'(mis2), 32'h1);
        size = 2'b00;
        clr_lsb = 1;
        pass(2, 32'h0000_1000, 32'h0000_0001, 1'b1, qs);
        check("w2_clr_lsb", 32'(lsb2), 32'h0);
        check("w2_clr_ext", ext2, 32'h0000_1000);
        clr_lsb = 0;
        pass(2, 32'h0000_1000, 32'h0000_0001, 1'b1, qs);
        check("w2_noclr_lsb", 32'(lsb2), 32'h1);

        pass(4, 32'h8000_0001, 32'h0, 1'b1, qs);
        shift_op = 1; right = 0; shamt = 4'd1;
        pass(4, 32'h0, 32'h0, 1'b0, qs);
        check("w4_sll1_stream", qs, 32'h0000_0002);
        check("w4_sll1_drain", adr4, 32'h0);
        shift_op = 0;
        pass(4, 32'h1234_5678, 32'h0, 1'b1, qs);
        shift_op = 1; right = 1; shamt = 4'd0;
        pass(4, 32'h0, 32'h0, 1'b0, qs);
        check("w4_sr0_stream", qs, 32'h1234_5678);
        shift_op = 0;
        pass(4, 32'h1234_5678, 32'h0, 1'b1, qs);
        shift_op = 1; right = 1; shamt = 4'd1;
        pass(4, 32'h0, 32'h0, 1'b0, qs);
        check("w4_sr1_stream", qs, 32'h91A2_B3C0);
        shift_op = 0; right = 0; shamt = 4'd0;

        pass(4, 32'h8000_0000, 32'h0, 1'b1, qs);
        sh_signed = 1;
        pass(4, 32'h0, 32'h0, 1'b0, qs);
        check("w4_sra_stream", qs, 32'h8000_0000);
        check("w4_sra_fill", adr4, 32'hFFFF_FFFC);
        sh_signed = 0;
        pass(4, 32'h8000_0000, 32'h0, 1'b1, qs);
        pass(4, 32'h0, 32'h0, 1'b0, qs);
        check("w4_srl_fill", adr4, 32'h0);

        size = 2'b10;
        mdu_op = 1;
        pass(8, 32'h0000_0103, 32'h0, 1'b1, qs);
        check("w8_mdu_lsb", 32'(lsb8), 32'h0);
        check("w8_mis", 32'(mis8), 32'h1);
        mdu_op = 0;
        #1;
        check("w8_lsb", 32'(lsb8), 32'h3);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cnt0  = (k == 0);
            init  = 1;
            rs1_c = 8'(32'h1234_5678 >> (8 * k));
            imm_c = 8'(32'h1111_1111 >> (8 * k));
            en8   = 1;
        end
        #2 rst = 1;
        #1;
        check("w8_rst_adr", adr8, 32'h0);
        check("w8_rst_mis", 32'(mis8), 32'h0);
        check("w8_rst_q", 32'(q8), 32'h0);
        check("w8_rst_lsb", 32'(lsb8), 32'h0);
        @(negedge clk);
        rst = 0; en8 = 0; cnt0 = 0; init = 0;
        pass(8, 32'h1234_5678, 32'h1111_1111, 1'b1, qs);
        check("w8_fresh_ext", ext8, 32'h2345_6789);
        check("w8_fresh_mis", 32'(mis8), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
